// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// Parametrised up/down counter with a post-reset init period and a ready flag.
// After reset release the block spends INIT_CYCLES clock edges in INIT, holding
// d_out at zero and ignoring all datapath controls. It then moves to RUN and
// raises rdy. In RUN the counter loads, counts up or counts down modulo
// MAX_VAL+1. A registered one-cycle d_wrap flag marks every edge that hits the
// terminal value.
//
// Build option (define to enable):
//   PARAM_UPDOWN_COUNTER_SAT_EN - saturating mode. Counting up at MAX_VAL
//     holds MAX_VAL, and counting down at 0 holds 0. d_wrap is raised for every
//     enabled edge that is blocked at a limit. Load, rdy, reset and INIT
//     behaviour are the same in both builds.
//
// Parameters:
//   WIDTH       counter width in bits (>= 2)
//   MAX_VAL     terminal count, 0 .. 2^WIDTH-1
//   INIT_CYCLES clock edges after reset release before rdy rises (>= 1)
//
// Ports:
//   clock       in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   d_en        in   1      count enable
//   d_dir       in   1      1 = count up, 0 = count down
//   d_load      in   1      synchronous load strobe (has priority over d_en)
//   d_load_val  in   WIDTH  load value, clipped to MAX_VAL
//   d_out       out  WIDTH  registered count
//   d_wrap      out  1      registered wrap/limit flag
//   rdy         out  1      registered ready flag, high once INIT is complete
// -----------------------------------------------------------------------------
module param_updown_counter #(
    parameter int              WIDTH       = 12,
    parameter longint unsigned MAX_VAL     = 4095,
    parameter int              INIT_CYCLES = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             d_en,
    input  logic             d_dir,
    input  logic             d_load,
    input  logic [WIDTH-1:0] d_load_val,
    output logic [WIDTH-1:0] d_out,
    output logic             d_wrap,
    output logic             rdy
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (WIDTH < 2) begin : g_bad_width
        $error("param_updown_counter: WIDTH must be >= 2");
    end

    if ((WIDTH < 64) && (MAX_VAL >= (64'd1 << WIDTH))) begin : g_bad_max
        $error("param_updown_counter: MAX_VAL does not fit in WIDTH bits");
    end

    if (INIT_CYCLES < 1) begin : g_bad_init
        $error("param_updown_counter: INIT_CYCLES must be >= 1");
    end

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    // The init counter only has to reach INIT_CYCLES-1, so it gets the
    // narrowest width that holds that value (at least one bit).
    localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    localparam logic [ICW-1:0]   INIT_LAST = ICW'(INIT_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_W    = '0;
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]       state;
    logic [ICW-1:0]   init_cnt;

    logic [WIDTH-1:0] next_out;
    logic             next_wrap;
    logic [WIDTH-1:0] load_clip;

    // Clip the load value against the terminal count over the full width.
    assign load_clip = (d_load_val > MAX_W) ? MAX_W : d_load_val;

    // -------------------------------------------------------------------------
    // Next-value logic for the RUN datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        next_out  = d_out;
        next_wrap = 1'b0;

        if (d_load) begin
            next_out  = load_clip;
            next_wrap = 1'b0;
        end else if (d_en) begin
            if (d_dir) begin
                if (d_out == MAX_W) begin
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
                    next_out  = MAX_W;
`else
                    next_out  = ZERO_W;
`endif
                    next_wrap = 1'b1;
                end else begin
                    next_out = d_out + ONE_W;
                end
            end else begin
                if (d_out == ZERO_W) begin
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
                    next_out  = ZERO_W;
`else
                    next_out  = MAX_W;
`endif
                    next_wrap = 1'b1;
                end else begin
                    next_out = d_out - ONE_W;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequential logic: FSM, init counter, datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            rdy      <= 1'b0;
            d_out    <= '0;
            d_wrap   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    // The datapath stays parked at zero and all controls are
                    // ignored until the init period has elapsed.
                    d_out  <= '0;
                    d_wrap <= 1'b0;
                    if (init_cnt == INIT_LAST) begin
                        state <= ST_RUN;
                        rdy   <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + ICW'(1);
                    end
                end
                ST_RUN: begin
                    rdy    <= 1'b1;
                    d_out  <= next_out;
                    d_wrap <= next_wrap;
                end
                default: begin
                    state <= ST_INIT;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_param_updown_counter
//
// Directed bench for param_updown_counter. It uses two instances:
//   u_dut  - default parameters (12-bit, MAX_VAL 4095, INIT_CYCLES 4)
//   u_dut9 - 4-bit, MAX_VAL 9, INIT_CYCLES 1 (clip and short-init corners)
// Expected values are hand-computed. Where the saturating build differs, the
// expectation is chosen by the same build macro.
// -----------------------------------------------------------------------------
module tb_param_updown_counter;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;

    logic        d_en = 1'b0, d_dir = 1'b1, d_load = 1'b0;
    logic [11:0] d_load_val = '0;
    logic [11:0] d_out;
    logic        d_wrap, rdy;

    logic        e9_en = 1'b0, e9_dir = 1'b1, e9_load = 1'b0;
    logic [3:0]  e9_load_val = '0;
    logic [3:0]  d9_out;
    logic        d9_wrap, rdy9;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    param_updown_counter #(.WIDTH(12), .MAX_VAL(4095), .INIT_CYCLES(4)) u_dut (
        .clock(clock), .rst_n(rst_n), .d_en(d_en), .d_dir(d_dir),
        .d_load(d_load), .d_load_val(d_load_val),
        .d_out(d_out), .d_wrap(d_wrap), .rdy(rdy)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .INIT_CYCLES(1)) u_dut9 (
        .clock(clock), .rst_n(rst_n), .d_en(e9_en), .d_dir(e9_dir),
        .d_load(e9_load), .d_load_val(e9_load_val),
        .d_out(d9_out), .d_wrap(d9_wrap), .rdy(rdy9)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk12(input string tag, input logic [11:0] e_out, input logic e_wrap);
        check({tag, ".out"},  32'(d_out),  32'(e_out));
        check({tag, ".wrap"}, 32'(d_wrap), 32'(e_wrap));
    endtask

    task automatic chk9(input string tag, input logic [3:0] e_out, input logic e_wrap);
        check({tag, ".out"},  32'(d9_out),  32'(e_out));
        check({tag, ".wrap"}, 32'(d9_wrap), 32'(e_wrap));
    endtask

    initial begin
        int          errs;
        int          wraps;
        logic [11:0] exp_out;
        logic        exp_wrap;

        // ---------------- 1. reset and INIT period ----------------
        d_en = 1'b1; d_dir = 1'b1;
        #12;
        chk12("rst", 12'h000, 1'b0);
        check("rst.rdy", 32'(rdy), 32'd0);
        check("rst.rdy9", 32'(rdy9), 32'd0);
        rst_n = 1'b1;                          // released away from an edge

        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("init%0d.rdy", i), 32'(rdy), 32'd0);
            check($sformatf("init%0d.out", i), 32'(d_out), 32'd0);
            check($sformatf("init%0d.rdy9", i), 32'(rdy9), 32'd1);
        end
        step();
        check("init4.rdy", 32'(rdy), 32'd1);
        chk12("init4", 12'h000, 1'b0);

        // ---------------- 2. 4096 up-count edges ----------------
        errs = 0; wraps = 0; exp_out = 12'h000;
        for (int i = 0; i < 4096; i++) begin
            step();
            exp_wrap = (exp_out == 12'hFFF);
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
            exp_out = (exp_out == 12'hFFF) ? 12'hFFF : exp_out + 12'h001;
`else
            exp_out = exp_out + 12'h001;
`endif
            if (d_out !== exp_out || d_wrap !== exp_wrap) errs++;
            if (d_wrap === 1'b1) wraps++;
        end
        check("up4096.errs", 32'(errs), 32'd0);
        check("up4096.wraps", 32'(wraps), 32'd1);
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
        chk12("up4096.end", 12'hFFF, 1'b1);
`else
        chk12("up4096.end", 12'h000, 1'b1);
`endif
        check("up4096.idle9", 32'(d9_out), 32'd0);

        // ---------------- 3. load priority and wrap ----------------
        d_load = 1'b1; d_load_val = 12'h123; d_en = 1'b1;
        step(); chk12("ld123", 12'h123, 1'b0);
        d_load_val = 12'hFFE;
        step(); chk12("ldFFE", 12'hFFE, 1'b0);
        d_load = 1'b0;
        step(); chk12("upFFF", 12'hFFF, 1'b0);
        step();
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
        chk12("up_wrap", 12'hFFF, 1'b1);
`else
        chk12("up_wrap", 12'h000, 1'b1);
`endif
        d_en = 1'b0;
        step();
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
        chk12("hold", 12'hFFF, 1'b0);
`else
        chk12("hold", 12'h000, 1'b0);
`endif

        // down through zero, then immediate direction change
        d_load = 1'b1; d_load_val = 12'h000;
        step(); chk12("ld0", 12'h000, 1'b0);
        d_load = 1'b0; d_en = 1'b1; d_dir = 1'b0;
        step();
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
        chk12("dn_wrap", 12'h000, 1'b1);
`else
        chk12("dn_wrap", 12'hFFF, 1'b1);
`endif
        d_dir = 1'b1;
        step();
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
        chk12("dir_up", 12'h001, 1'b0);
`else
        chk12("dir_up", 12'h000, 1'b1);
`endif

        // ---------------- 6. limit at MAX_VAL, both builds ----------------
        d_load = 1'b1; d_load_val = 12'hFFF;
        step(); chk12("sat_ld", 12'hFFF, 1'b0);
        d_load = 1'b0;
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
        step(); chk12("sat_up1", 12'hFFF, 1'b1);
        step(); chk12("sat_up2", 12'hFFF, 1'b1);
        step(); chk12("sat_up3", 12'hFFF, 1'b1);
        d_dir = 1'b0;
        step(); chk12("sat_dn", 12'hFFE, 1'b0);
`else
        step(); chk12("sat_up1", 12'h000, 1'b1);
        step(); chk12("sat_up2", 12'h001, 1'b0);
        step(); chk12("sat_up3", 12'h002, 1'b0);
        d_dir = 1'b0;
        step(); chk12("sat_dn", 12'h001, 1'b0);
`endif
        d_en = 1'b0; d_dir = 1'b1;

        // ---------------- 4. MAX_VAL=9 instance ----------------
        e9_en = 1'b1; e9_dir = 1'b0;
        step();
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
        chk9("m9_dn", 4'd0, 1'b1);
`else
        chk9("m9_dn", 4'd9, 1'b1);
`endif
        e9_load = 1'b1; e9_load_val = 4'd15;
        step(); chk9("m9_ld15", 4'd9, 1'b0);
        e9_load_val = 4'd10;
        step(); chk9("m9_ld10", 4'd9, 1'b0);
        e9_load_val = 4'd8;
        step(); chk9("m9_ld8", 4'd8, 1'b0);
        e9_load_val = 4'd9;
        step(); chk9("m9_ld9", 4'd9, 1'b0);
        e9_load = 1'b0; e9_dir = 1'b1;
        step();
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
        chk9("m9_up", 4'd9, 1'b1);
`else
        chk9("m9_up", 4'd0, 1'b1);
`endif
        e9_load = 1'b1; e9_load_val = 4'd9; e9_dir = 1'b0;
        step();
        e9_load = 1'b0;
        step(); chk9("m9_dn8", 4'd8, 1'b0);
        e9_en = 1'b0;

        // ---------------- 5. mid-run reset ----------------
        d_load = 1'b1; d_load_val = 12'h054;
        step();
        d_load = 1'b0; d_en = 1'b1; d_dir = 1'b1;
        step(); chk12("pre_rst", 12'h055, 1'b0);
        #2 rst_n = 1'b0;                       // between edges
        #1;
        chk12("mid_rst", 12'h000, 1'b0);
        check("mid_rst.rdy", 32'(rdy), 32'd0);
        check("mid_rst.rdy9", 32'(rdy9), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("reinit%0d.rdy", i), 32'(rdy), 32'd0);
            check($sformatf("reinit%0d.out", i), 32'(d_out), 32'd0);
        end
        step();
        check("reinit4.rdy", 32'(rdy), 32'd1);
        step(); chk12("rerun", 12'h001, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
